rob_mc: RTL and testbench

Multi-channel reorder buffer, the parametrised successor to the single-channel ROB. It accepts tagged read requests from one upstream port and steers each request to one of NCH memory channels by address. Each channel can stall requests and return responses out of order. Responses go back upstream strictly in request-acceptance order, carrying the original ID and param. It sits between the request master and a banked or multi-port memory subsystem.

---
 rtl/rob_mc.sv | 163 ++++++++++++++++
 tb/tb_rob_mc.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_mc.sv
// rob_mc: multi-channel reorder buffer.
// Requests are steered to a memory channel by the low address bits and tagged
// with their ROB slot. Channels may answer out of order. Responses leave upstream
// in acceptance order, carrying the stored ID and param.
//
// Handshake: every valid/ready pair transfers exactly on a clock edge where both
// are high. Valid never waits for ready. req_ready is combinational from
// occupancy and the selected channel's ready. It never looks at rsp_ready, so
// a retire from a full buffer opens req_ready only on the following cycle.
module rob_mc #(
    parameter  int ROB_SIZE = 8,
    parameter  int NCH      = 2,
    parameter  int AWIDTH   = 32,
    parameter  int DWIDTH   = 32,
    parameter  int PWIDTH   = 8,
    parameter  int IDWIDTH  = 4,
    localparam int SWIDTH   = $clog2(ROB_SIZE),
    localparam int CWIDTH   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_val,
    input  logic [AWIDTH-1:0]       req_addr,
    input  logic [IDWIDTH-1:0]      req_ID,
    input  logic [PWIDTH-1:0]       req_param,
    output logic                    req_ready,
    output logic                    rsp_val,
    output logic [DWIDTH-1:0]       rsp_data,
    output logic [IDWIDTH-1:0]      rsp_ID,
    output logic [PWIDTH-1:0]       rsp_param,
    input  logic                    rsp_ready,
    output logic [NCH-1:0]          mem_req_val,
    output logic [NCH*AWIDTH-1:0]   mem_req_addr,
    output logic [NCH*SWIDTH-1:0]   mem_req_ID,
    input  logic [NCH-1:0]          mem_req_ready,
    input  logic [NCH-1:0]          mem_rsp_val,
    input  logic [NCH*SWIDTH-1:0]   mem_rsp_ID,
    input  logic [NCH*DWIDTH-1:0]   mem_rsp_data,
    output logic [SWIDTH:0]         count,
    output logic                    err_spurious
);

    localparam logic [SWIDTH:0] FULL_CNT = (SWIDTH + 1)'(ROB_SIZE);

    logic [CWIDTH-1:0]  ch;
    logic               accept;
    logic               retire;

    logic [SWIDTH-1:0]  wptr_q, wptr_d;
    logic [SWIDTH-1:0]  rptr_q, rptr_d;
    logic [SWIDTH:0]    count_q, count_d;
    logic [ROB_SIZE-1:0] alloc_q, alloc_d;
    logic [ROB_SIZE-1:0] done_q, done_d;
    logic               err_q, err_d;
    logic [IDWIDTH-1:0] id_q    [ROB_SIZE];
    logic [IDWIDTH-1:0] id_d    [ROB_SIZE];
    logic [PWIDTH-1:0]  param_q [ROB_SIZE];
    logic [PWIDTH-1:0]  param_d [ROB_SIZE];
    logic [DWIDTH-1:0]  data_q  [ROB_SIZE];
    logic [DWIDTH-1:0]  data_d  [ROB_SIZE];

    // A single-channel build has no select bits; everything goes to channel 0.
    if (NCH > 1) begin : g_ch_sel
        assign ch = req_addr[CWIDTH-1:0];
    end else begin : g_ch_zero
        assign ch = '0;
    end

    assign req_ready    = !rst && (count_q < FULL_CNT) && mem_req_ready[ch];
    assign accept       = req_val && req_ready;
    assign rsp_val      = alloc_q[rptr_q] && done_q[rptr_q];
    assign retire       = rsp_val && rsp_ready;
    assign rsp_data     = data_q[rptr_q];
    assign rsp_ID       = id_q[rptr_q];
    assign rsp_param    = param_q[rptr_q];
    assign count        = count_q;
    assign err_spurious = err_q;

    // Combinational pass-through of the accepted request to its channel, tag = wptr.
    always_comb begin
        mem_req_val  = '0;
        mem_req_addr = '0;
        mem_req_ID   = '0;
        for (int c = 0; c < NCH; c++) begin
            mem_req_addr[c*AWIDTH +: AWIDTH] = req_addr;
            mem_req_ID[c*SWIDTH +: SWIDTH]   = wptr_q;
            mem_req_val[c]                   = accept && (ch == CWIDTH'(c));
        end
    end

    // Next state of the entries and pointers. The order is: allocate, then capture responses, then retire.
    // A response may target the slot that is being allocated in the same cycle.
    // That is what lets a zero-latency memory reach rsp_val one cycle after the accept.
    always_comb begin
        alloc_d = alloc_q;
        done_d  = done_q;
        id_d    = id_q;
        param_d = param_q;
        data_d  = data_q;
        err_d   = err_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;

        if (accept) begin
            alloc_d[wptr_q] = 1'b1;
            done_d[wptr_q]  = 1'b0;
            id_d[wptr_q]    = req_ID;
            param_d[wptr_q] = req_param;
            wptr_d          = wptr_q + 1'b1;
        end

        for (int c = 0; c < NCH; c++) begin
            if (mem_rsp_val[c]) begin
                if (alloc_d[mem_rsp_ID[c*SWIDTH +: SWIDTH]] && !done_q[mem_rsp_ID[c*SWIDTH +: SWIDTH]]) begin
                    done_d[mem_rsp_ID[c*SWIDTH +: SWIDTH]] = 1'b1;
                    data_d[mem_rsp_ID[c*SWIDTH +: SWIDTH]] = mem_rsp_data[c*DWIDTH +: DWIDTH];
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        if (retire) begin
            alloc_d[rptr_q] = 1'b0;
            done_d[rptr_q]  = 1'b0;
            rptr_d          = rptr_q + 1'b1;
        end

        case ({accept, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register. Reset discards every in-flight entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            alloc_q <= alloc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Payload storage. The alloc and done bits qualify it, so it needs no reset.
    always_ff @(posedge clk) begin
        id_q    <= id_d;
        param_q <= param_d;
        data_q  <= data_d;
    end

endmodule

// File: tb/tb_rob_mc.sv
// tb_rob_mc: directed vector table plus hand-written multi-cycle sequences for rob_mc.
module tb_rob_mc;

    localparam int NC = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int PW = 8;
    localparam int IW = 4;
    localparam int SW = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_val;
    logic [AW-1:0]      req_addr;
    logic [IW-1:0]      req_ID;
    logic [PW-1:0]      req_param;
    logic               req_ready;
    logic               rsp_val;
    logic [DW-1:0]      rsp_data;
    logic [IW-1:0]      rsp_ID;
    logic [PW-1:0]      rsp_param;
    logic               rsp_ready;
    logic [NC-1:0]      mem_req_val;
    logic [NC*AW-1:0]   mem_req_addr;
    logic [NC*SW-1:0]   mem_req_ID;
    logic [NC-1:0]      mem_req_ready;
    logic [NC-1:0]      mem_rsp_val;
    logic [NC*SW-1:0]   mem_rsp_ID;
    logic [NC*DW-1:0]   mem_rsp_data;
    logic [SW:0]        count;
    logic               err_spurious;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rob_mc dut (
        .clk           (clk),
        .rst           (rst),
        .req_val       (req_val),
        .req_addr      (req_addr),
        .req_ID        (req_ID),
        .req_param     (req_param),
        .req_ready     (req_ready),
        .rsp_val       (rsp_val),
        .rsp_data      (rsp_data),
        .rsp_ID        (rsp_ID),
        .rsp_param     (rsp_param),
        .rsp_ready     (rsp_ready),
        .mem_req_val   (mem_req_val),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ID    (mem_req_ID),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_val   (mem_rsp_val),
        .mem_rsp_ID    (mem_rsp_ID),
        .mem_rsp_data  (mem_rsp_data),
        .count         (count),
        .err_spurious  (err_spurious)
    );

    // One vector = one clock cycle: the inputs for that cycle and the required outputs.
    typedef struct {
        logic            do_rst;
        logic            req_val;
        logic [AW-1:0]   addr;
        logic [IW-1:0]   id;
        logic [PW-1:0]   prm;
        logic            rsp_ready;
        logic [NC-1:0]   mrdy;
        logic [NC-1:0]   mval;
        logic [NC*SW-1:0] mtag;
        logic [NC*DW-1:0] mdata;
        logic            e_rdy;
        logic [NC-1:0]   e_mval;
        logic [SW-1:0]   e_tag;
        logic            e_rval;
        logic [DW-1:0]   e_data;
        logic [IW-1:0]   e_id;
        logic [PW-1:0]   e_prm;
        logic [SW:0]     e_cnt;
        logic            e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t idle(input logic [SW:0] cnt);
        vec_t v;
        v.do_rst = 1'b0; v.req_val = 1'b0; v.addr = '0; v.id = '0; v.prm = '0;
        v.rsp_ready = 1'b1; v.mrdy = '1; v.mval = '0; v.mtag = '0; v.mdata = '0;
        v.e_rdy = 1'b1; v.e_mval = '0; v.e_tag = '0; v.e_rval = 1'b0;
        v.e_data = '0; v.e_id = '0; v.e_prm = '0; v.e_cnt = cnt; v.e_err = 1'b0;
        return v;
    endfunction

    function automatic vec_t req(input vec_t vi, input logic [AW-1:0] a, input logic [IW-1:0] id,
                                 input logic [PW-1:0] p, input logic [SW-1:0] tag, input logic [NC-1:0] emv);
        vec_t v = vi;
        v.req_val = 1'b1; v.addr = a; v.id = id; v.prm = p;
        v.e_mval = emv; v.e_tag = tag;
        return v;
    endfunction

    function automatic vec_t rsp_in(input vec_t vi, input int c, input logic [SW-1:0] tag, input logic [DW-1:0] d);
        vec_t v = vi;
        v.mval[c] = 1'b1;
        v.mtag[c*SW +: SW] = tag;
        v.mdata[c*DW +: DW] = d;
        return v;
    endfunction

    function automatic vec_t head(input vec_t vi, input logic [DW-1:0] d, input logic [IW-1:0] id, input logic [PW-1:0] p);
        vec_t v = vi;
        v.e_rval = 1'b1; v.e_data = d; v.e_id = id; v.e_prm = p;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        req_val = 1'b0; req_addr = '0; req_ID = '0; req_param = '0;
        rsp_ready = 1'b1; mem_req_ready = '1;
        mem_rsp_val = '0; mem_rsp_ID = '0; mem_rsp_data = '0;
    endtask

    // One reset cycle with a request offered, then check the post-reset state.
    task automatic do_reset();
        @(negedge clk);
        set_idle();
        rst = 1'b1; req_val = 1'b1;
        #1;
        chk("rst.req_ready", 64'(req_ready), 64'd0);
        chk("rst.mem_req_val", 64'(mem_req_val), 64'd0);
        @(negedge clk);
        rst = 1'b0; set_idle();
        #1;
        chk("rst.count", 64'(count), 64'd0);
        chk("rst.rsp_val", 64'(rsp_val), 64'd0);
        chk("rst.err", 64'(err_spurious), 64'd0);
    endtask

    task automatic drive(input vec_t v);
        req_val = v.req_val; req_addr = v.addr; req_ID = v.id; req_param = v.prm;
        rsp_ready = v.rsp_ready; mem_req_ready = v.mrdy;
        mem_rsp_val = v.mval; mem_rsp_ID = v.mtag; mem_rsp_data = v.mdata;
    endtask

    task automatic check_vec(input vec_t v, input int i);
        int c;
        chk($sformatf("v%0d.req_ready", i), 64'(req_ready), 64'(v.e_rdy));
        chk($sformatf("v%0d.mem_req_val", i), 64'(mem_req_val), 64'(v.e_mval));
        if (v.e_mval != '0) begin
            c = v.e_mval[1] ? 1 : 0;
            chk($sformatf("v%0d.mem_tag", i), 64'(mem_req_ID[c*SW +: SW]), 64'(v.e_tag));
            chk($sformatf("v%0d.mem_addr", i), 64'(mem_req_addr[c*AW +: AW]), 64'(v.addr));
        end
        chk($sformatf("v%0d.rsp_val", i), 64'(rsp_val), 64'(v.e_rval));
        if (v.e_rval) begin
            chk($sformatf("v%0d.rsp_data", i), 64'(rsp_data), 64'(v.e_data));
            chk($sformatf("v%0d.rsp_ID", i), 64'(rsp_ID), 64'(v.e_id));
            chk($sformatf("v%0d.rsp_param", i), 64'(rsp_param), 64'(v.e_prm));
        end
        chk($sformatf("v%0d.count", i), 64'(count), 64'(v.e_cnt));
        chk($sformatf("v%0d.err", i), 64'(err_spurious), 64'(v.e_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        set_idle();

        // Single request: tag 0 answered two cycles after the accept.
        v = req(idle(0), 32'h10, 4'd3, 8'hA5, 3'd0, 2'b01); v.do_rst = 1'b1; vecs.push_back(v);
        vecs.push_back(idle(1));
        vecs.push_back(rsp_in(idle(1), 0, 3'd0, 32'hDEADBEEF));
        vecs.push_back(head(idle(1), 32'hDEADBEEF, 4'd3, 8'hA5));
        vecs.push_back(idle(0));

        // Reorder: tags 0..3 alternate ch0/ch1 and are answered in the order 3,1,2,0.
        v = req(idle(0), 32'h0, 4'd1, 8'h10, 3'd0, 2'b01); v.do_rst = 1'b1; vecs.push_back(v);
        vecs.push_back(req(idle(1), 32'h1, 4'd2, 8'h11, 3'd1, 2'b10));
        vecs.push_back(req(idle(2), 32'h2, 4'd3, 8'h12, 3'd2, 2'b01));
        vecs.push_back(req(idle(3), 32'h3, 4'd4, 8'h13, 3'd3, 2'b10));
        for (int k = 4; k < 7; k++) vecs.push_back(idle(4));
        vecs.push_back(rsp_in(idle(4), 1, 3'd3, 32'h0000_3333));
        vecs.push_back(rsp_in(idle(4), 1, 3'd1, 32'h0000_1111));
        vecs.push_back(rsp_in(idle(4), 0, 3'd2, 32'h0000_2222));
        vecs.push_back(rsp_in(idle(4), 0, 3'd0, 32'hA000_0000));
        vecs.push_back(head(idle(4), 32'hA000_0000, 4'd1, 8'h10));
        vecs.push_back(head(idle(3), 32'h0000_1111, 4'd2, 8'h11));
        vecs.push_back(head(idle(2), 32'h0000_2222, 4'd3, 8'h12));
        vecs.push_back(head(idle(1), 32'h0000_3333, 4'd4, 8'h13));
        vecs.push_back(idle(0));

        // Simultaneous responses on both channels.
        v = req(idle(0), 32'h0, 4'd5, 8'h50, 3'd0, 2'b01); v.do_rst = 1'b1; vecs.push_back(v);
        vecs.push_back(req(idle(1), 32'h1, 4'd6, 8'h60, 3'd1, 2'b10));
        vecs.push_back(rsp_in(rsp_in(idle(2), 0, 3'd0, 32'hAAAA_0000), 1, 3'd1, 32'hBBBB_1111));
        vecs.push_back(head(idle(2), 32'hAAAA_0000, 4'd5, 8'h50));
        vecs.push_back(head(idle(1), 32'hBBBB_1111, 4'd6, 8'h60));
        vecs.push_back(idle(0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_rst) do_reset();
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_vec(vecs[i], i);
        end

        // Full and backpressure, including the write pointer wrapping to tag 0.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_idle(); rsp_ready = 1'b0;
            req_val = 1'b1; req_addr = AW'(i); req_ID = IW'(i); req_param = PW'(8'h80 + i);
            #1;
            chk("full.req_ready", 64'(req_ready), 64'd1);
            chk("full.count", 64'(count), 64'(i));
            chk("full.tag", 64'(mem_req_ID[(i%2)*SW +: SW]), 64'(i));
        end
        @(negedge clk);
        set_idle(); rsp_ready = 1'b0;
        req_val = 1'b1; req_addr = 32'h8; req_ID = 4'd8; req_param = 8'h88;
        mem_rsp_val = 2'b01; mem_rsp_ID = '0; mem_rsp_data = 64'h0000_0900;
        #1;
        chk("full9.count", 64'(count), 64'd8);
        chk("full9.req_ready", 64'(req_ready), 64'd0);
        chk("full9.mem_req_val", 64'(mem_req_val), 64'd0);
        @(negedge clk);
        mem_rsp_val = '0; rsp_ready = 1'b1;
        #1;
        chk("full_retire.req_ready", 64'(req_ready), 64'd0);
        chk("full_retire.rsp_val", 64'(rsp_val), 64'd1);
        chk("full_retire.rsp_data", 64'(rsp_data), 64'h900);
        chk("full_retire.rsp_ID", 64'(rsp_ID), 64'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("wrap.count", 64'(count), 64'd7);
        chk("wrap.req_ready", 64'(req_ready), 64'd1);
        chk("wrap.mem_req_val", 64'(mem_req_val), 64'b01);
        chk("wrap.tag", 64'(mem_req_ID[0 +: SW]), 64'd0);
        chk("wrap.rsp_val", 64'(rsp_val), 64'd0);
        @(negedge clk);
        set_idle(); rsp_ready = 1'b0;
        #1;
        chk("wrap_full.count", 64'(count), 64'd8);
        chk("wrap_full.req_ready", 64'(req_ready), 64'd0);

        // Channel stall: ch1 not ready blocks only requests to ch1.
        do_reset();
        @(negedge clk);
        set_idle(); mem_req_ready = 2'b01; req_val = 1'b1; req_addr = 32'h1;
        #1;
        chk("stall.req_ready", 64'(req_ready), 64'd0);
        chk("stall.mem_req_val", 64'(mem_req_val), 64'd0);
        @(negedge clk);
        req_addr = 32'h2;
        #1;
        chk("stall_ch0.req_ready", 64'(req_ready), 64'd1);
        chk("stall_ch0.mem_req_val", 64'(mem_req_val), 64'b01);
        chk("stall_ch0.tag", 64'(mem_req_ID[0 +: SW]), 64'd0);
        @(negedge clk);
        set_idle(); mem_req_ready = 2'b01;
        #1;
        chk("stall_ch0.count", 64'(count), 64'd1);

        // Zero-latency memory: response in the accept cycle, head valid next cycle.
        do_reset();
        @(negedge clk);
        set_idle(); req_val = 1'b1; req_addr = 32'h0; req_ID = 4'd9; req_param = 8'h99;
        mem_rsp_val = 2'b01; mem_rsp_ID = '0; mem_rsp_data = 64'h1234_5678;
        #1;
        chk("zl.req_ready", 64'(req_ready), 64'd1);
        chk("zl.mem_req_val", 64'(mem_req_val), 64'b01);
        @(negedge clk);
        set_idle();
        #1;
        chk("zl.rsp_val", 64'(rsp_val), 64'd1);
        chk("zl.rsp_data", 64'(rsp_data), 64'h1234_5678);
        chk("zl.rsp_ID", 64'(rsp_ID), 64'd9);
        chk("zl.err", 64'(err_spurious), 64'd0);
        @(negedge clk);
        #1;
        chk("zl.count_after", 64'(count), 64'd0);
        chk("zl.rsp_val_after", 64'(rsp_val), 64'd0);

        // Reset mid-flight: a late response to tag 1 must be dropped and flagged.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_idle(); req_val = 1'b1; req_addr = AW'(i); req_ID = IW'(i);
        end
        @(negedge clk);
        set_idle();
        #1;
        chk("mid.count_before", 64'(count), 64'd3);
        do_reset();
        @(negedge clk);
        set_idle(); mem_rsp_val = 2'b10; mem_rsp_ID = 6'b001_000; mem_rsp_data = 64'hFFFF_FFFF_0000_0000;
        #1;
        chk("mid.err_before", 64'(err_spurious), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_idle();
            #1;
            chk("mid.err", 64'(err_spurious), 64'd1);
            chk("mid.rsp_val", 64'(rsp_val), 64'd0);
            chk("mid.count", 64'(count), 64'd0);
        end
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
